// File: rtl/ama_riscv_imm_gen_ctrl_if.sv
// Handshake bundle between fetch, the decode-stage imm-gen sequencer and downstream.
// master = fetch/downstream side, slave = sequencer.
interface ama_riscv_imm_gen_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic             flush;
   logic [2:0]       ig_sel;
   logic [24:0]      ig_in;
   logic             out_valid;
   logic             out_ready;
   logic             out_illegal;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output in_valid, in_inst, flush, out_ready,
      input  in_ready, ig_sel, ig_in, out_valid, out_illegal, hold_cnt
   );

   modport slave (
      input  in_valid, in_inst, flush, out_ready,
      output in_ready, ig_sel, ig_in, out_valid, out_illegal, hold_cnt
   );
endinterface

// File: rtl/ama_riscv_imm_gen_ctrl.sv
// Decode-stage sequencer: captures inst[31:7], decodes the imm-gen select and
// presents it downstream with stall (hold-previous) and flush-bubble handling.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | nothing held, ready to accept
// S_ISSUE | first presentation cycle of a captured instruction
// S_HOLD  | downstream stalled, imm gen disabled to re-drive held value
// S_FLUSH | fixed bubble after flush, counting down before accepting
module ama_riscv_imm_gen_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   ama_riscv_imm_gen_ctrl_if.slave       bus
);
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   localparam logic [2:0] SEL_DIS = 3'b000;
   localparam logic [2:0] SEL_I   = 3'b001;
   localparam logic [2:0] SEL_S   = 3'b010;
   localparam logic [2:0] SEL_B   = 3'b011;
   localparam logic [2:0] SEL_J   = 3'b100;
   localparam logic [2:0] SEL_U   = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_FLUSH} state_e;

   state_e            state_q, state_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [24:0]       ig_in_q;
   logic [2:0]        sel_q;
   logic              illegal_q;

   logic [2:0]        dec_sel;
   logic              dec_illegal;
   logic              capture;

   always_comb begin
      dec_sel     = SEL_DIS;
      dec_illegal = 1'b0;
      case (bus.in_inst[6:0])
         7'b0000011, 7'b0010011,
         7'b1100111, 7'b1110011: dec_sel = SEL_I;
         7'b0100011:             dec_sel = SEL_S;
         7'b1100011:             dec_sel = SEL_B;
         7'b1101111:             dec_sel = SEL_J;
         7'b0110111, 7'b0010111: dec_sel = SEL_U;
         7'b0110011:             dec_sel = SEL_DIS;
         default:                dec_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      capture       = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.ig_sel    = SEL_DIS;
      case (state_q)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               capture = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE, S_HOLD: begin
            bus.out_valid = 1'b1;
            bus.in_ready  = bus.out_ready;
            if (state_q == S_ISSUE) bus.ig_sel = sel_q;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  capture = 1'b1;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_HOLD;
            end
         end
         S_FLUSH: begin
            if (fcnt_q == '0) state_d = S_IDLE;
            else              fcnt_d  = fcnt_q - 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // flush overrides every event, including a pending transfer or capture
      if (bus.flush) begin
         state_d       = S_FLUSH;
         fcnt_d        = FC_LOAD;
         capture       = 1'b0;
         bus.in_ready  = 1'b0;
         bus.out_valid = 1'b0;
         bus.ig_sel    = SEL_DIS;
      end
   end

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (state_q == S_HOLD && hold_cnt_q != '1) hold_cnt_d = hold_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fcnt_q     <= '0;
         hold_cnt_q <= '0;
         ig_in_q    <= '0;
         sel_q      <= SEL_DIS;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fcnt_q     <= fcnt_d;
         hold_cnt_q <= hold_cnt_d;
         if (capture) begin
            ig_in_q   <= bus.in_inst[31:7];
            sel_q     <= dec_sel;
            illegal_q <= dec_illegal;
         end
      end
   end

   assign bus.ig_in       = ig_in_q;
   assign bus.out_illegal = illegal_q;
   assign bus.hold_cnt    = hold_cnt_q;
endmodule

// File: tb/tb_ama_riscv_imm_gen_ctrl.sv
// Bench for the imm-gen sequencer: directed scenarios plus random traffic
// against a transaction-level model; a CNT_W=2 copy shadows the main DUT.
module tb_ama_riscv_imm_gen_ctrl;
   localparam int FC = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ama_riscv_imm_gen_ctrl_if #(.CNT_W(8)) bus ();
   ama_riscv_imm_gen_ctrl_if #(.CNT_W(2)) bus2 ();

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.in_inst   = bus.in_inst;
   assign bus2.flush     = bus.flush;
   assign bus2.out_ready = bus.out_ready;

   ama_riscv_imm_gen_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(8)) u_dut (
      .clk (clk), .rst (rst), .bus (bus.slave));
   ama_riscv_imm_gen_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(2)) u_dut_sat (
      .clk (clk), .rst (rst), .bus (bus2.slave));

   int total = 0;
   int bad   = 0;

   // model: at most one instruction held; fresh = not yet presented before
   bit          m_have, m_fresh, m_ill;
   logic [2:0]  m_sel;
   logic [24:0] m_ig;
   int          m_bubble, m_hold;

   logic        e_valid, e_ready, e_ill;
   logic [2:0]  e_sel;
   logic [24:0] e_ig;
   logic [7:0]  e_hc;
   logic [1:0]  e_hc2;

   function automatic void ref_decode(input logic [6:0] op, output logic [2:0] sel,
                                      output logic ill);
      sel = 3'd0; ill = 1'b0;
      if (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011) sel = 3'd1;
      else if (op == 7'b0100011) sel = 3'd2;
      else if (op == 7'b1100011) sel = 3'd3;
      else if (op == 7'b1101111) sel = 3'd4;
      else if (op == 7'b0110111 || op == 7'b0010111) sel = 3'd5;
      else if (op != 7'b0110011) ill = 1'b1;
   endfunction

   task automatic model_reset();
      m_have = 0; m_fresh = 0; m_ill = 0; m_sel = 0; m_ig = 0; m_bubble = 0; m_hold = 0;
   endtask

   task automatic set_in(input logic v, input logic [31:0] inst, input logic fl,
                         input logic ordy);
      bus.in_valid = v; bus.in_inst = inst; bus.flush = fl; bus.out_ready = ordy;
      @(negedge clk);
      e_ig  = m_ig;
      e_ill = m_ill;
      if (m_bubble > 0) begin
         e_valid = 0; e_ready = 0; e_sel = 0;
      end else if (m_have) begin
         e_valid = !fl; e_ready = !fl && ordy; e_sel = (m_fresh && !fl) ? m_sel : 3'd0;
      end else begin
         e_valid = 0; e_ready = !fl; e_sel = 0;
      end
      e_hc  = (m_hold > 255) ? 8'd255 : 8'(m_hold);
      e_hc2 = (m_hold > 3) ? 2'd3 : 2'(m_hold);
   endtask

   task automatic tick();
      bit acc;
      @(posedge clk);
      if (m_have && !m_fresh) m_hold++;
      if (bus.flush) begin
         m_have = 0; m_bubble = FC;
      end else if (m_bubble > 0) begin
         m_bubble--;
      end else begin
         acc = bus.in_valid && (!m_have || bus.out_ready);
         if (m_have && bus.out_ready) m_have = 0;
         else if (m_have) m_fresh = 0;
         if (acc) begin
            m_have = 1; m_fresh = 1; m_ig = bus.in_inst[31:7];
            ref_decode(bus.in_inst[6:0], m_sel, m_ill);
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      bus.in_valid = 0; bus.in_inst = 0; bus.flush = 0; bus.out_ready = 0;
      rst = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 0; bus.in_inst = 0; bus.flush = 0; bus.out_ready = 0;
      model_reset();
      #3;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready); end
      total++; if (bus.ig_sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", bus.ig_sel); end
      total++; if (bus.ig_in !== 25'd0) begin bad++; $display("FAIL reset_ig_in got=%0h want=0", bus.ig_in); end
      total++; if (bus.hold_cnt !== 8'd0) begin bad++; $display("FAIL reset_hold got=%0d want=0", bus.hold_cnt); end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_addi();
      set_in(1, 32'h00500093, 0, 1);
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL addi_idle got rdy=%0b vld=%0b want 1/0", bus.in_ready, bus.out_valid); end
      tick();
      set_in(0, 0, 0, 1);
      total++; if (bus.out_valid !== 1'b1 || bus.ig_sel !== 3'b001) begin bad++; $display("FAIL addi_issue got vld=%0b sel=%0d want 1/1", bus.out_valid, bus.ig_sel); end
      total++; if (bus.ig_in !== 25'h00A001) begin bad++; $display("FAIL addi_ig_in got=%0h want=00a001", bus.ig_in); end
      tick();
      set_in(0, 0, 0, 1);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL addi_back_idle got vld=%0b rdy=%0b want 0/1", bus.out_valid, bus.in_ready); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] insts [4] = '{32'h00112623, 32'hFE000EE3, 32'h008000EF, 32'h123452B7};
      logic [2:0]  sels  [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
      set_in(1, insts[0], 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(i < 3, (i < 3) ? insts[i+1] : 32'h0, 0, 1);
         total++; if (bus.ig_sel !== sels[i] || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_%0d got sel=%0d rdy=%0b vld=%0b want sel=%0d 1/1", i, bus.ig_sel, bus.in_ready, bus.out_valid, sels[i]);
         end
         total++; if (bus.ig_in !== insts[i][31:7]) begin bad++; $display("FAIL b2b_ig_in_%0d got=%0h want=%0h", i, bus.ig_in, insts[i][31:7]); end
         tick();
      end
   endtask

   task automatic test_hold();
      set_in(1, 32'h00002003, 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 32'h00500093, 0, i == 3);
         total++; if (bus.ig_sel !== ((i == 0) ? 3'd1 : 3'd0) || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL hold_sel_%0d got sel=%0d vld=%0b want sel=%0d vld=1", i, bus.ig_sel, bus.out_valid, (i == 0) ? 1 : 0);
         end
         total++; if (bus.in_ready !== (i == 3)) begin bad++; $display("FAIL hold_ready_%0d got=%0b want=%0b", i, bus.in_ready, i == 3); end
         tick();
      end
      set_in(0, 0, 0, 1);
      total++; if (bus.hold_cnt !== 8'd3) begin bad++; $display("FAIL hold_cnt got=%0d want=3", bus.hold_cnt); end
      total++; if (bus.ig_sel !== 3'd1 || bus.ig_in !== 25'h00A001) begin bad++; $display("FAIL hold_release got sel=%0d ig=%0h want 1/00a001", bus.ig_sel, bus.ig_in); end
      tick();
   endtask

   task automatic test_flush();
      set_in(1, 32'h00002003, 0, 1); tick();
      set_in(0, 0, 0, 0); tick();
      set_in(1, 32'h00500093, 1, 1);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_cycle got vld=%0b rdy=%0b want 0/0", bus.out_valid, bus.in_ready); end
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'h00500093, 0, 1);
         total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== (i == 2)) begin
            bad++; $display("FAIL flush_bubble_%0d got vld=%0b rdy=%0b want 0/%0b", i, bus.out_valid, bus.in_ready, i == 2);
         end
         tick();
      end
      set_in(0, 0, 1, 1); tick();
      set_in(0, 0, 0, 1); tick();
      set_in(1, 32'h00500093, 1, 1); tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 32'h00500093, 0, 1);
         total++; if (bus.in_ready !== (i == 2) || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_reload_%0d got rdy=%0b vld=%0b want %0b/0", i, bus.in_ready, bus.out_valid, i == 2);
         end
         tick();
      end
      set_in(0, 0, 0, 1);
      total++; if (bus.hold_cnt !== 8'd4) begin bad++; $display("FAIL flush_hold_cnt got=%0d want=4", bus.hold_cnt); end
      tick();
   endtask

   task automatic test_illegal();
      set_in(1, 32'h0000000B, 0, 1); tick();
      set_in(1, 32'h002081B3, 0, 1);
      total++; if (bus.out_illegal !== 1'b1 || bus.ig_sel !== 3'd0 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL illegal_op got ill=%0b sel=%0d vld=%0b rdy=%0b want 1/0/1/1", bus.out_illegal, bus.ig_sel, bus.out_valid, bus.in_ready);
      end
      tick();
      set_in(0, 0, 0, 1);
      total++; if (bus.out_illegal !== 1'b0 || bus.ig_sel !== 3'd0 || bus.out_valid !== 1'b1) begin
         bad++; $display("FAIL illegal_add got ill=%0b sel=%0d vld=%0b want 0/0/1", bus.out_illegal, bus.ig_sel, bus.out_valid);
      end
      tick();
   endtask

   task automatic test_random();
      logic [6:0]  ops [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111, 7'b0110011,
                                7'b0001011, 7'b1111111};
      logic [31:0] r;
      for (int n = 0; n < 2000; n++) begin
         r = $urandom();
         set_in($urandom_range(0, 3) != 0, {r[31:7], ops[$urandom_range(0, 11)]},
                $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
         total++; if (bus.out_valid !== e_valid) begin bad++; $display("FAIL rnd_valid@%0d got=%0b want=%0b", n, bus.out_valid, e_valid); end
         total++; if (bus.in_ready !== e_ready) begin bad++; $display("FAIL rnd_ready@%0d got=%0b want=%0b", n, bus.in_ready, e_ready); end
         total++; if (bus.ig_sel !== e_sel) begin bad++; $display("FAIL rnd_sel@%0d got=%0d want=%0d", n, bus.ig_sel, e_sel); end
         total++; if (bus.ig_in !== e_ig) begin bad++; $display("FAIL rnd_ig_in@%0d got=%0h want=%0h", n, bus.ig_in, e_ig); end
         total++; if (bus.hold_cnt !== e_hc || bus2.hold_cnt !== e_hc2) begin
            bad++; $display("FAIL rnd_hold@%0d got=%0d/%0d want=%0d/%0d", n, bus.hold_cnt, bus2.hold_cnt, e_hc, e_hc2);
         end
         if (e_valid) begin
            total++; if (bus.out_illegal !== e_ill) begin bad++; $display("FAIL rnd_illegal@%0d got=%0b want=%0b", n, bus.out_illegal, e_ill); end
         end
         tick();
      end
   endtask

   task automatic test_saturate_reset();
      apply_reset();
      set_in(1, 32'h00002003, 0, 1); tick();
      for (int i = 0; i < 6; i++) begin set_in(0, 0, 0, 0); tick(); end
      set_in(0, 0, 0, 0);
      total++; if (bus.hold_cnt !== 8'd5 || bus2.hold_cnt !== 2'd3) begin
         bad++; $display("FAIL sat_hold got=%0d/%0d want=5/3", bus.hold_cnt, bus2.hold_cnt);
      end
      #2 rst = 1'b1;
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.ig_sel !== 3'd0 || bus.in_ready !== 1'b1) begin
         bad++; $display("FAIL rst_mid_hold got vld=%0b sel=%0d rdy=%0b want 0/0/1", bus.out_valid, bus.ig_sel, bus.in_ready);
      end
      total++; if (bus.hold_cnt !== 8'd0 || bus2.hold_cnt !== 2'd0 || bus.ig_in !== 25'd0) begin
         bad++; $display("FAIL rst_mid_hold_regs got hc=%0d/%0d ig=%0h want 0/0/0", bus.hold_cnt, bus2.hold_cnt, bus.ig_in);
      end
      model_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      set_in(1, 32'h123452B7, 0, 1); tick();
      set_in(0, 0, 0, 1);
      total++; if (bus.ig_sel !== 3'd5 || bus.out_valid !== 1'b1) begin
         bad++; $display("FAIL post_reset got sel=%0d vld=%0b want 5/1", bus.ig_sel, bus.out_valid);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_hold();
      test_flush();
      test_illegal();
      test_random();
      test_saturate_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule
